// File: rtl/alu_exerciser_if.sv
// Operand/command/result bus between the exerciser (master) and the combinational alu (slave).
interface alu_exerciser_if #(
   parameter int WIDTH = 3,
   parameter int CMD_W = 3
);
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [CMD_W-1:0] alu_cmd;
   logic [WIDTH-1:0] alu_res;

   modport master (output alu_a, alu_b, alu_cmd, input alu_res);
   modport slave  (input alu_a, alu_b, alu_cmd, output alu_res);
endinterface

// File: rtl/alu_exerciser.sv
// Single-clock board exerciser for the alu: debounced buttons, operand/guess registers, scoring.
// Optional feature macro ALU_EXERCISER_AUTOSTEP_EN: a passing check steps alu_cmd and clears guess.
module alu_exerciser #(
   parameter int WIDTH       = 3,
   parameter int CMD_W       = 3,
   parameter int A_INIT      = 4,
   parameter int B_INIT      = 5,
   parameter int CMD_INIT    = 1,
   parameter int DEB_CYCLES  = 16,
   parameter int SHOW_CYCLES = 8,
   parameter int SCORE_W     = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 btn_cmd,
   input  logic                 btn_guess,
   input  logic                 btn_load_a,
   input  logic                 btn_load_b,
   input  logic                 btn_check,
   input  logic [WIDTH-1:0]     sw,
   alu_exerciser_if.master      alu,
   output logic [WIDTH-1:0]     guess,
   output logic                 led_match,
   output logic                 led_pass,
   output logic                 led_fail,
   output logic [SCORE_W-1:0]   score
);
   localparam int NB  = 5;
   localparam int DW  = $clog2(DEB_CYCLES);
   localparam int SCW = $clog2(SHOW_CYCLES + 1);

   localparam logic [1:0] ST_SETTLE = 2'd0;
   localparam logic [1:0] ST_READY  = 2'd1;
   localparam logic [1:0] ST_SHOW   = 2'd2;

   // Bit order doubles as priority: lowest index wins.
   logic [NB-1:0] btn_raw, sync1, sync2, level, press;
   logic [DW-1:0] deb_cnt [NB];

   assign btn_raw = {btn_check, btn_guess, btn_cmd, btn_load_b, btn_load_a};

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
         level <= '0;
         press <= '0;
         for (int i = 0; i < NB; i++) deb_cnt[i] <= '0;
      end else begin
         sync1 <= btn_raw;
         sync2 <= sync1;
         press <= '0;
         for (int i = 0; i < NB; i++) begin
            if (sync2[i] == level[i]) begin
               deb_cnt[i] <= '0;
            end else if (deb_cnt[i] == DW'(DEB_CYCLES - 1)) begin
               level[i]   <= sync2[i];
               press[i]   <= sync2[i];
               deb_cnt[i] <= '0;
            end else begin
               deb_cnt[i] <= deb_cnt[i] + 1'b1;
            end
         end
      end
   end

   logic [1:0]       state;
   logic [SCW-1:0]   show_cnt;
   logic [WIDTH-1:0] res_q;
   logic             do_load_a, do_load_b, do_cmd, do_guess, do_check, reload, hit;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      {do_check, do_guess, do_cmd, do_load_b, do_load_a} = '0;
      if (state != ST_SHOW) begin
         if (press[0])      do_load_a = 1'b1;
         else if (press[1]) do_load_b = 1'b1;
         else if (press[2]) do_cmd    = 1'b1;
         else if (press[3]) do_guess  = 1'b1;
         else if (press[4]) do_check  = 1'b1;
      end
   end

   assign reload = do_load_a | do_load_b | do_cmd;
   assign hit    = (guess == res_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         alu.alu_a   <= WIDTH'(A_INIT);
         alu.alu_b   <= WIDTH'(B_INIT);
         alu.alu_cmd <= CMD_W'(CMD_INIT);
         guess       <= '0;
         score       <= '0;
         res_q       <= '0;
         led_match   <= 1'b0;
         led_pass    <= 1'b0;
         led_fail    <= 1'b0;
         show_cnt    <= '0;
         state       <= ST_SETTLE;
      end else begin
         // Lags state/guess/res_q by one cycle, so it reads 0 the cycle after SETTLE.
         led_match <= (state != ST_SETTLE) && hit;
         if (do_load_a) alu.alu_a   <= sw;
         if (do_load_b) alu.alu_b   <= sw;
         if (do_cmd)    alu.alu_cmd <= alu.alu_cmd + 1'b1;
         if (do_guess)  guess       <= guess + 1'b1;
         case (state)
            ST_SETTLE: begin
               if (!reload) begin
                  state <= ST_READY;
                  res_q <= alu.alu_res;
               end
            end
            ST_READY: begin
               if (reload) begin
                  state <= ST_SETTLE;
               end else if (do_check) begin
                  state    <= ST_SHOW;
                  show_cnt <= SCW'(SHOW_CYCLES - 1);
                  led_pass <= hit;
                  led_fail <= !hit;
                  if (hit && score != '1) score <= score + 1'b1;
               end
            end
            ST_SHOW: begin
               if (show_cnt == '0) begin
                  led_pass <= 1'b0;
                  led_fail <= 1'b0;
`ifdef ALU_EXERCISER_AUTOSTEP_EN
                  if (led_pass) begin
                     alu.alu_cmd <= alu.alu_cmd + 1'b1;
                     guess       <= '0;
                     state       <= ST_SETTLE;
                  end else begin
                     state <= ST_READY;
                  end
`else
                  state <= ST_READY;
`endif
               end else begin
                  show_cnt <= show_cnt - 1'b1;
               end
            end
            default: state <= ST_SETTLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_exerciser.sv
// Bench for alu_exerciser: a cycle model checked every cycle plus directed literal expectations.
module tb_alu_exerciser;
   localparam int WIDTH   = 3;
   localparam int CMD_W   = 3;
   localparam int DEB     = 4;
   localparam int SHOW    = 8;
   localparam int SCORE_W = 8;
   localparam int MOD_W   = 1 << WIDTH;
   localparam int MOD_C   = 1 << CMD_W;
   localparam int SCORE_MAX = (1 << SCORE_W) - 1;
   localparam int B_LA = 0, B_LB = 1, B_CMD = 2, B_GUESS = 3, B_CHECK = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [4:0] btn = '0;
   logic [WIDTH-1:0] sw = '0;
   logic [WIDTH-1:0] guess;
   logic led_match, led_pass, led_fail;
   logic [SCORE_W-1:0] score;

   int n_checks = 0;
   int n_fail   = 0;
   int pass_cnt, fail_cnt;

   alu_exerciser_if #(.WIDTH(WIDTH), .CMD_W(CMD_W)) alu ();
   assign alu.alu_res = WIDTH'(alu.alu_a + alu.alu_b);

   alu_exerciser #(
      .WIDTH(WIDTH), .CMD_W(CMD_W), .A_INIT(4), .B_INIT(5), .CMD_INIT(1),
      .DEB_CYCLES(DEB), .SHOW_CYCLES(SHOW), .SCORE_W(SCORE_W)
   ) dut (
      .clk(clk), .rst(rst),
      .btn_cmd(btn[B_CMD]), .btn_guess(btn[B_GUESS]), .btn_load_a(btn[B_LA]),
      .btn_load_b(btn[B_LB]), .btn_check(btn[B_CHECK]),
      .sw(sw), .alu(alu), .guess(guess), .led_match(led_match),
      .led_pass(led_pass), .led_fail(led_fail), .score(score)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural model: registers as integers, buttons judged by run length of synchronised samples.
   typedef enum {M_SETTLE, M_READY, M_SHOW} mode_t;
   mode_t m_mode;
   int m_a, m_b, m_cmd, m_guess, m_score, m_res_q, m_show_left;
   bit m_match, m_pass, m_fail, m_ok = 1'b0;
   bit d1 [5], d2 [5], lvl [5], prev [5], m_press [5];
   int run [5];
   int act, res;
   bit reload, s;

   always @(posedge clk) begin
      if (rst) begin
         m_mode = M_SETTLE; m_a = 4; m_b = 5; m_cmd = 1; m_guess = 0; m_score = 0;
         m_res_q = 0; m_show_left = 0; m_match = 0; m_pass = 0; m_fail = 0; m_ok = 1;
         for (int i = 0; i < 5; i++) begin
            d1[i] = 0; d2[i] = 0; lvl[i] = 0; prev[i] = 0; m_press[i] = 0; run[i] = 0;
         end
      end else begin
         act = -1;
         if (m_mode != M_SHOW)
            for (int i = 0; i < 5; i++) if (m_press[i] && act < 0) act = i;
         res     = (m_a + m_b) % MOD_W;
         m_match = (m_mode != M_SETTLE) && (m_guess == m_res_q);
         case (act)
            B_LA:    m_a = int'(sw);
            B_LB:    m_b = int'(sw);
            B_CMD:   m_cmd = (m_cmd + 1) % MOD_C;
            B_GUESS: m_guess = (m_guess + 1) % MOD_W;
            default: ;
         endcase
         reload = (act == B_LA) || (act == B_LB) || (act == B_CMD);
         case (m_mode)
            M_SETTLE: if (!reload) begin m_mode = M_READY; m_res_q = res; end
            M_READY: begin
               if (reload) m_mode = M_SETTLE;
               else if (act == B_CHECK) begin
                  m_mode = M_SHOW; m_show_left = SHOW;
                  m_pass = (m_guess == m_res_q); m_fail = !m_pass;
                  if (m_pass && m_score < SCORE_MAX) m_score++;
               end
            end
            default: begin
               m_show_left--;
               if (m_show_left == 0) begin
`ifdef ALU_EXERCISER_AUTOSTEP_EN
                  if (m_pass) begin m_cmd = (m_cmd + 1) % MOD_C; m_guess = 0; m_mode = M_SETTLE; end
                  else m_mode = M_READY;
`else
                  m_mode = M_READY;
`endif
                  m_pass = 0; m_fail = 0;
               end
            end
         endcase
         for (int i = 0; i < 5; i++) begin
            s = d2[i]; d2[i] = d1[i]; d1[i] = btn[i];
            run[i] = (s == prev[i]) ? run[i] + 1 : 1;
            prev[i] = s;
            m_press[i] = (run[i] >= DEB) && (s != lvl[i]) && s;
            if (run[i] >= DEB) lvl[i] = s;
         end
      end
   end

   always @(negedge clk) begin
      if (m_ok) begin
         check("cyc_alu_a", int'(alu.alu_a), m_a);
         check("cyc_alu_b", int'(alu.alu_b), m_b);
         check("cyc_alu_cmd", int'(alu.alu_cmd), m_cmd);
         check("cyc_guess", int'(guess), m_guess);
         check("cyc_led_match", int'(led_match), int'(m_match));
         check("cyc_led_pass", int'(led_pass), int'(m_pass));
         check("cyc_led_fail", int'(led_fail), int'(m_fail));
         check("cyc_score", int'(score), m_score);
      end
   end

   task automatic drive(input logic [4:0] v, input int n);
      btn = v;
      repeat (n) begin
         @(negedge clk);
         pass_cnt += int'(led_pass);
         fail_cnt += int'(led_fail);
      end
   endtask

   task automatic press(input int idx);
      logic [4:0] v;
      v = '0;
      v[idx] = 1'b1;
      drive(v, 8);
      drive('0, 12);
   endtask

   initial begin
      logic [4:0] v;
      pass_cnt = 0; fail_cnt = 0;
      repeat (3) @(negedge clk);
      check("rst_alu_a", int'(alu.alu_a), 4);
      check("rst_alu_b", int'(alu.alu_b), 5);
      check("rst_alu_cmd", int'(alu.alu_cmd), 1);
      check("rst_guess", int'(guess), 0);
      check("rst_score", int'(score), 0);
      check("rst_leds", int'({led_match, led_pass, led_fail}), 0);
      rst = 1'b0;
      drive('0, 4);

      // Bouncing guess button: 1-0-1 then steady.
      v = '0; v[B_GUESS] = 1'b1;
      drive(v, 1); drive('0, 1); drive(v, 1); drive(v, 20); drive('0, 12);
      check("bounce_guess", int'(guess), 1);
      check("match_after_guess", int'(led_match), 1);

      // (4+5) mod 8 = 1 matches guess 1.
      pass_cnt = 0; fail_cnt = 0;
      press(B_CHECK);
      check("pass_cycles", pass_cnt, SHOW);
      check("pass_no_fail", fail_cnt, 0);
      check("score_one", int'(score), 1);

      press(B_GUESS);
      check("guess_two", int'(guess), 2);
      check("nomatch_two", int'(led_match), 0);

      // Wrong guess; cmd pressed one cycle later lands inside SHOW and is dropped.
      pass_cnt = 0; fail_cnt = 0;
      v = '0; v[B_CHECK] = 1'b1;
      drive(v, 1);
      v[B_CMD] = 1'b1;
      drive(v, 7);
      drive('0, 12);
      check("fail_cycles", fail_cnt, SHOW);
      check("fail_no_pass", pass_cnt, 0);
      check("score_kept", int'(score), 1);
      check("cmd_ignored_show", int'(alu.alu_cmd), 1);

      for (int i = 0; i < 8; i++) press(B_GUESS);
      check("guess_wrap", int'(guess), 2);
      for (int i = 0; i < 7; i++) press(B_CMD);
      check("cmd_wrap", int'(alu.alu_cmd), 0);

      // load_a beats cmd in the same cycle.
      sw = 3'd6;
      v = '0; v[B_LA] = 1'b1; v[B_CMD] = 1'b1;
      drive(v, 8); drive('0, 12);
      check("load_a_six", int'(alu.alu_a), 6);
      check("cmd_dropped", int'(alu.alu_cmd), 0);
      check("nomatch_res3", int'(led_match), 0);
      press(B_GUESS);
      check("match_res3", int'(led_match), 1);
      pass_cnt = 0;
      press(B_CHECK);
      check("pass_cycles_2", pass_cnt, SHOW);
      check("score_two", int'(score), 2);

      sw = 3'd2;
      press(B_LB);
      check("load_b_two", int'(alu.alu_b), 2);

      // Reset while a failing check is on display.
      v = '0; v[B_CHECK] = 1'b1;
      drive(v, 10);
      check("show_fail_on", int'(led_fail), 1);
      btn = '0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("rst_show_fail", int'(led_fail), 0);
      check("rst_show_pass", int'(led_pass), 0);
      check("rst_show_score", int'(score), 0);
      check("rst_show_a", int'(alu.alu_a), 4);
      @(negedge clk);
      rst = 1'b0;
      drive('0, 6);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
